// File: rtl/spad_pkg.sv
// Shared definitions for the PE scratchpad FIFOs: spad kinds, default
// geometries and the DEPTH-aware circular pointer increment.
package spad_pkg;

  typedef enum logic [1:0] {
    SPAD_IFMAP  = 2'd0,
    SPAD_FILTER = 2'd1,
    SPAD_PSUM   = 2'd2
  } spad_mode_e;

  localparam int IFMAP_DW     = 16;
  localparam int IFMAP_DEPTH  = 12;
  localparam int FILTER_DW    = 16;
  localparam int FILTER_DEPTH = 224;
  localparam int PSUM_DW      = 16;
  localparam int PSUM_DEPTH   = 24;

  function automatic int unsigned spad_depth(input spad_mode_e mode);
    case (mode)
      SPAD_IFMAP:  return 32'(IFMAP_DEPTH);
      SPAD_FILTER: return 32'(FILTER_DEPTH);
      SPAD_PSUM:   return 32'(PSUM_DEPTH);
      default:     return 32'(IFMAP_DEPTH);
    endcase
  endfunction

  // Wraps at depth-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/spad_mem.sv
// Scratchpad storage: one write port, one synchronous read port, no array reset.
module spad_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 12,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write and registered read; the FIFO never reads the slot it is writing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/spad_fifo.sv
// Scratchpad FIFO with peek, retain-on-read window mode, rewind and release.
// Pointers: base_ptr (oldest retained) <= rd_ptr (next unread) <= wr_ptr.
module spad_fifo
  import spad_pkg::*;
#(
  parameter int DATA_WIDTH = IFMAP_DW,
  parameter int DEPTH      = IFMAP_DEPTH,
  parameter int PTR_W      = $clog2(DEPTH),
  parameter int CNT_W      = $clog2(DEPTH + 1),
  parameter int AF_LEVEL   = DEPTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_clr,
  input  logic                  rd_clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_inc,
  input  logic                  rd_keep,
  input  logic                  rd_release,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      avail,
  output logic                  err_ovf,
  output logic                  err_udf
);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, base_ptr;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  push, rd_ok, adv, pop, rel, none_held;
  logic [CNT_W-1:0]      count_nxt, avail_nxt;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return PTR_W'(ptr_inc(32'(p), 32'(DEPTH)));
  endfunction

  // Retained-but-read entries are count-avail; pointer equality alone is ambiguous when full.
  assign none_held = (count == avail);

  // Event decode; clears override read-side pointer effects but not the data read.
  always_comb begin
    push  = wr_en & ~full & ~wr_clr;
    rd_ok = rd_en & ~empty;
    adv   = rd_ok & rd_inc & ~rd_clr & ~wr_clr;
    pop   = adv & ~rd_keep & none_held;
    rel   = rd_release & ~none_held & ~rd_clr & ~wr_clr;
  end

  // Next occupancy counts.
  always_comb begin
    count_nxt = count;
    avail_nxt = avail;
    if (wr_clr) begin
      count_nxt = {CNT_W{1'b0}};
      avail_nxt = {CNT_W{1'b0}};
    end else begin
      count_nxt = count + CNT_W'(push) - CNT_W'(pop | rel);
      if (rd_clr) begin
        avail_nxt = count_nxt;
      end else begin
        avail_nxt = avail + CNT_W'(push) - CNT_W'(adv);
      end
    end
  end

  spad_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_ok),
    .rd_addr (rd_ptr),
    .rd_data (mem_q)
  );

  assign rd_data = rd_valid ? mem_q : {DATA_WIDTH{1'b0}};

  // Pointers, counts, flags and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= {PTR_W{1'b0}};
      rd_ptr      <= {PTR_W{1'b0}};
      base_ptr    <= {PTR_W{1'b0}};
      count       <= {CNT_W{1'b0}};
      avail       <= {CNT_W{1'b0}};
      full        <= 1'b0;
      almost_full <= 1'b0;
      empty       <= 1'b1;
      rd_valid    <= 1'b0;
      err_ovf     <= 1'b0;
      err_udf     <= 1'b0;
    end else begin
      if (wr_clr) begin
        wr_ptr   <= {PTR_W{1'b0}};
        rd_ptr   <= {PTR_W{1'b0}};
        base_ptr <= {PTR_W{1'b0}};
      end else begin
        if (push) wr_ptr <= nxt(wr_ptr);
        if (rd_clr) rd_ptr <= base_ptr;
        else if (adv) rd_ptr <= nxt(rd_ptr);
        if (pop | rel) base_ptr <= nxt(base_ptr);
      end
      count       <= count_nxt;
      avail       <= avail_nxt;
      full        <= (count_nxt == CNT_W'(DEPTH));
      almost_full <= (count_nxt >= CNT_W'(AF_LEVEL));
      empty       <= (avail_nxt == {CNT_W{1'b0}});
      rd_valid    <= rd_ok;
      if (wr_en & full) err_ovf <= 1'b1;
      if ((rd_en & empty) | (rd_release & none_held)) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spad_fifo.sv
// Randomised and directed bench for spad_fifo against a queue-based model.
module tb_spad_fifo;

  localparam int DEPTH = 12;
  localparam int AF    = 10;

  logic        clk = 1'b0;
  logic        rst, wr_clr, rd_clr, wr_en, rd_en, rd_inc, rd_keep, rd_release;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid, full, almost_full, empty, err_ovf, err_udf;
  logic [3:0]  count, avail;

  int n_cmp = 0;
  int n_fail = 0;

  spad_fifo dut (
    .clk(clk), .rst(rst), .wr_clr(wr_clr), .rd_clr(rd_clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_inc(rd_inc),
    .rd_keep(rd_keep), .rd_release(rd_release), .rd_data(rd_data),
    .rd_valid(rd_valid), .full(full), .almost_full(almost_full), .empty(empty),
    .count(count), .avail(avail), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: q holds retained entries oldest first; the first rd_off of them are already read.
  logic [15:0] q[$];
  int          rd_off, sz, av, off0;
  bit          pfull, pempty, rok;
  logic [15:0] exp_data;
  bit          exp_valid, exp_ovf, exp_udf;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      rd_off = 0; exp_data = 16'h0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_udf = 1'b0;
    end else begin
      sz = q.size(); av = sz - rd_off; off0 = rd_off;
      pfull = (sz == DEPTH); pempty = (av == 0);
      rok = rd_en && !pempty;
      exp_valid = rok;
      exp_data = rok ? q[rd_off] : 16'h0;
      if (wr_en && pfull) exp_ovf = 1'b1;
      if ((rd_en && pempty) || (rd_release && off0 == 0)) exp_udf = 1'b1;
      if (wr_clr) begin
        q.delete(); rd_off = 0;
      end else begin
        if (rd_clr) rd_off = 0;
        else begin
          if (rok && rd_inc) begin
            if (!rd_keep && off0 == 0) void'(q.pop_front());
            else rd_off++;
          end
          if (rd_release && off0 > 0) begin
            void'(q.pop_front()); rd_off--;
          end
        end
        if (wr_en && !pfull) q.push_back(wr_data);
      end
    end
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("avail", 32'(avail), 32'(q.size() - rd_off));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("empty", 32'(empty), 32'(q.size() == rd_off));
    chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
    chk("rd_data", 32'(rd_data), 32'(exp_data));
    chk("err_ovf", 32'(err_ovf), 32'(exp_ovf));
    chk("err_udf", 32'(err_udf), 32'(exp_udf));
  end

  task automatic drive(input bit w, input logic [15:0] d, input bit r, input bit inc,
                       input bit keep, input bit rel, input bit rc, input bit wc);
    wr_en = w; wr_data = d; rd_en = r; rd_inc = inc; rd_keep = keep;
    rd_release = rel; rd_clr = rc; wr_clr = wc;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 16'h0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  logic [15:0] win [3];

  initial begin
    rst = 1'b1;
    wr_en = 0; wr_data = 16'h0; rd_en = 0; rd_inc = 0; rd_keep = 0;
    rd_release = 0; rd_clr = 0; wr_clr = 0;
    repeat (2) @(negedge clk);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    rst = 1'b0;

    // Fill to full, then overflow.
    for (int i = 1; i <= 12; i++) begin
      drive(1, 16'(i), 0, 0, 0, 0, 0, 0);
      if (i == 9)  chk("af_at_9", 32'(almost_full), 32'd0);
      if (i == 10) chk("af_at_10", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd12);
    drive(1, 16'h000D, 0, 0, 0, 0, 0, 0);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd12);

    // Drain with pops, then underflow.
    for (int i = 1; i <= 12; i++) begin
      drive(0, 16'h0, 1, 1, 0, 0, 0, 0);
      chk("pop_data", 32'(rd_data), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_count", 32'(count), 32'd0);
    drive(0, 16'h0, 1, 1, 0, 0, 0, 0);
    chk("udf_valid", 32'(rd_valid), 32'd0);
    chk("udf_flag", 32'(err_udf), 32'd1);

    // Peek repeats the head word.
    do_reset();
    for (int i = 1; i <= 3; i++) drive(1, 16'(i), 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 16'h0, 1, 0, 0, 0, 0, 0);
      chk("peek_data", 32'(rd_data), 32'h1);
      chk("peek_avail", 32'(avail), 32'd3);
    end

    // Window mode: read-keep, rewind, release.
    do_reset();
    win[0] = 16'hA; win[1] = 16'hB; win[2] = 16'hC;
    for (int i = 0; i < 3; i++) drive(1, win[i], 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 16'h0, 1, 1, 1, 0, 0, 0);
    chk("win_avail0", 32'(avail), 32'd0);
    chk("win_count3", 32'(count), 32'd3);
    drive(0, 16'h0, 0, 0, 0, 0, 1, 0);
    chk("win_rewind", 32'(avail), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0, 1, 1, 1, 0, 0, 0);
      chk("win_reread", 32'(rd_data), 32'(win[i]));
    end
    drive(0, 16'h0, 0, 0, 0, 1, 0, 0);
    chk("win_release", 32'(count), 32'd2);
    drive(0, 16'h0, 0, 0, 0, 0, 1, 0);
    drive(0, 16'h0, 1, 0, 0, 0, 0, 0);
    chk("win_after_rel", 32'(rd_data), 32'hB);

    // Simultaneous push/pop across the pointer wrap.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1, 16'(100 + i), 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 16'(200 + i), 1, 1, 0, 0, 0, 0);
      chk("wrap_count", 32'(count), 32'd5);
    end
    chk("wrap_ovf", 32'(err_ovf), 32'd0);
    chk("wrap_udf", 32'(err_udf), 32'd0);

    // Write clear together with push and read.
    drive(1, 16'hBEEF, 1, 1, 0, 0, 0, 1);
    chk("wclr_count", 32'(count), 32'd0);
    chk("wclr_empty", 32'(empty), 32'd1);
    chk("wclr_data", 32'(rd_data), 32'd215);
    drive(0, 16'h0, 1, 0, 0, 0, 0, 0);
    chk("wclr_dropped", 32'(rd_valid), 32'd0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 99) < 55, 16'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 2);
    end
    rst = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spad_fifo.md
# spad_fifo

Single-clock, parametrised scratchpad FIFO for the PE datapath (ifmap/filter/psum spads). It replaces the dual-pointer, flag-less FIFO generation and adds:
- full/empty flags and occupancy counts;
- peek reads and sliding-window reuse, i.e. retain-on-read, rewind and release;
- overflow/underflow error flags.

It sits between the GLB/NoC delivery port and the PE MAC operand mux.

## Interface
- DATA_WIDTH, 16, entry width
- DEPTH, 12, entries; any value ≥ 2, not necessarily a power of two
- PTR_W, $clog2(DEPTH), pointer width
- CNT_W, $clog2(DEPTH+1), count width
- AF_LEVEL, DEPTH-2, almost_full threshold
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- wr_clr  in  1  sync clear of write side: wr_ptr, base_ptr and rd_ptr go to 0, contents invalidated
- rd_clr  in  1  sync clear of read side: rd_ptr <= base_ptr
- wr_en  in  1  push wr_data
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read the entry at rd_ptr
- rd_inc  in  1  with rd_en: 1 advances rd_ptr, 0 is a peek
- rd_keep  in  1  with an advancing read: 1 retains the entry (window mode), 0 frees it (pop)
- rd_release  in  1  free the oldest retained entry (base_ptr++)
- rd_data  out  DATA_WIDTH  registered read data; 0 when rd_valid=0
- rd_valid  out  1  rd_data is valid this cycle
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_LEVEL
- empty  out  1  avail == 0 (nothing unread)
- count  out  CNT_W  retained entries, base_ptr..wr_ptr
- avail  out  CNT_W  unread entries, rd_ptr..wr_ptr
- err_ovf  out  1  sticky: push attempted while full
- err_udf  out  1  sticky: read or release attempted with nothing eligible

## Operation
- Pointers base_ptr ≤ rd_ptr ≤ wr_ptr, compared circularly. Every increment wraps DEPTH-1 -> 0.
- Push: wr_en & ~full writes mem[wr_ptr], then wr_ptr++. A push while full is dropped and sets err_ovf.
- Read: rd_en & ~empty registers mem[rd_ptr] into rd_data. rd_en while empty sets err_udf; rd_data becomes 0 and rd_valid 0.
- rd_inc=1 advances rd_ptr.
  - With rd_keep=0, base_ptr also advances (pop). This is legal only when base_ptr == rd_ptr. Otherwise it behaves as keep=1.
- rd_release: base_ptr++ if base_ptr != rd_ptr; otherwise ignored and err_udf is set.
- rd_clr rewinds reads to the oldest retained entry, for window reuse.
- Same-cycle priority: rst > wr_clr > rd_clr > {read, release}. The push is independent of this priority, except that it is blocked by rst and wr_clr.
- A rd_clr-cycle read returns mem[old rd_ptr]; the rewind takes effect next cycle.
- Push and free in the same cycle while full: the push is rejected, because full is evaluated on the pre-cycle count.
- Push while empty plus rd_en in the same cycle: underflow (no bypass).
- count and avail update as ±1 per event. The net change is 0 when a push and a free (or a push and an advance) occur together.
- Sticky errors clear only on rst.

## Timing
- Reset values: all pointers 0; rd_data 0, rd_valid 0, full 0, almost_full 0, empty 1, count 0, avail 0, err_ovf 0, err_udf 0.
- Read latency: 1 cycle. rd_en at edge N gives rd_data/rd_valid valid after edge N, held for one cycle only.
- Write-to-read: data pushed at edge N is readable by rd_en sampled at edge N+1.
- Flags and counts are registered and reflect all events of the previous edge.
- Peek repeated over k cycles returns the same word k times with rd_valid=1.

## Structure
- Package spad_pkg holds:
  - the ptr_inc wrap function (DEPTH-aware);
  - the spad mode encodings;
  - shared defaults for DATA_WIDTH and DEPTH per spad type (ifmap 12, filter 224, psum 24).
- One sub-module, spad_mem: single write port, single synchronous read port, no reset on the array.
- Pointer, count and flag logic stays in spad_fifo.

## Test plan
- Reset, then push 0x0001..0x000C (DEPTH=12) -> full=1, count=12, almost_full from count 10. A 13th push -> dropped, err_ovf=1, count stays 12.
- Pop all 12 with rd_inc=1, rd_keep=0 -> rd_data 0x0001..0x000C one cycle after each rd_en. Then empty=1, count=0. One extra rd_en -> rd_valid=0, err_udf=1.
- Push 3 words, then peek 4 cycles with rd_inc=0 -> rd_data=0x0001 four times, avail stays 3.
- Window mode: push A, B, C; read 3 with rd_keep=1 -> avail=0, count=3. rd_clr -> avail=3, and rereading yields A, B, C. rd_release once -> count=2; after a further rd_clr the next read returns B.
- Wrap: with DEPTH=12, perform 20 push/pop pairs in the same cycle, continuous -> count constant, data in order across the 11->0 wrap, no errors.
- wr_clr asserted together with wr_en, rd_en and a nonzero count -> next cycle count=0, empty=1, the push is discarded, and the read still returns the old entry.
